debug_trace_unit: RTL

Parametrised successor to the Plus Too single-breakpoint debug panel. It provides NUM_BP masked address breakpoints and a TRACE_DEPTH history of distinct CPU bus addresses. A DTACK-withholding halt/step FSM has a parametrised key debounce. It sits between the address decoder's _dtack and the 68000, and feeds the debug overlay through an indexed trace read port.

---
 rtl/debug_pkg.sv | 25 ++
 rtl/debug_trace_buffer.sv | 50 +++++
 rtl/debug_trace_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | debug_pkg                                                             |
// | Shared state encoding and index-width helpers for debug_trace_unit.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package debug_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_STEP    = 2'd2,
    ST_RELEASE = 2'd3
  } dbg_state_e;

  // An index port is never narrower than one bit, even for a single entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BP_IDX_W    = idx_w(4);
  localparam int TRACE_IDX_W = idx_w(8);

endpackage
`default_nettype wire

// File: rtl/debug_trace_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | debug_trace_buffer                                                    |
// | History of distinct bus addresses with saturating count and read port.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module debug_trace_buffer
  import debug_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DEPTH  = 8,
  localparam int IDX_W = idx_w(DEPTH)
) (
  input  logic              clk8,
  input  logic              reset,
  input  logic              sample_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [IDX_W:0]    count_o
);

  localparam logic [IDX_W:0] C_FULL = (IDX_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] curr_q;
  logic [ADDR_W-1:0] hist_q [DEPTH];
  logic [IDX_W:0]    count_q;
  logic              w_push;

  // Only a change of address is history; the departing address is recorded.
  assign w_push = sample_i && (addr_i != curr_q);

  always_ff @(posedge clk8) begin
    if (reset) begin
      curr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else if (w_push) begin
      curr_q    <= addr_i;
      hist_q[0] <= curr_q;
      for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
      if (count_q != C_FULL) count_q <= count_q + 1'b1;
    end
  end

  assign rd_addr_o = hist_q[rd_idx_i];
  assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/debug_trace_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | debug_trace_unit                                                      |
// | Masked breakpoints, address trace and DTACK halt/step control.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module debug_trace_unit
  import debug_pkg::*;
#(
  parameter int          ADDR_W      = 24,
  parameter int          NUM_BP      = 4,
  parameter int          TRACE_DEPTH = 8,
  parameter logic [15:0] DEBOUNCE    = 16'd50000,
  localparam int BP_W = idx_w(NUM_BP),
  localparam int TR_W = idx_w(TRACE_DEPTH)
) (
  input  logic              clk8,
  input  logic              reset,
  input  logic              halt_en,
  input  logic              _stepKey,
  input  logic              bp_we,
  input  logic [BP_W-1:0]   bp_sel,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] bp_mask,
  input  logic              bp_en,
  input  logic              videoBusControl,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic              _dtackIn,
  output logic              _dtackOut,
  output logic              halted,
  output logic              bp_hit,
  output logic [BP_W-1:0]   bp_hit_idx,
  input  logic [TR_W-1:0]   trace_rd_idx,
  output logic [ADDR_W-1:0] trace_rd_addr,
  output logic [TR_W:0]     trace_count
);

  logic [ADDR_W-1:0] bp_addr_q [NUM_BP];
  logic [ADDR_W-1:0] bp_mask_q [NUM_BP];
  logic [NUM_BP-1:0] bp_en_q;
  logic [NUM_BP-1:0] w_match;
  logic              w_match_any;
  logic [BP_W-1:0]   w_hit_idx;

  always_ff @(posedge clk8) begin
    if (reset) begin
      bp_en_q <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr_q[i] <= '0;
        bp_mask_q[i] <= '0;
      end
    end else if (bp_we) begin
      bp_addr_q[bp_sel] <= bp_addr;
      bp_mask_q[bp_sel] <= bp_mask;
      bp_en_q[bp_sel]   <= bp_en;
    end
  end

  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_match
    assign w_match[gi] = bp_en_q[gi] && !videoBusControl &&
                         (((cpuAddr ^ bp_addr_q[gi]) & ~bp_mask_q[gi]) == '0);
  end

  assign w_match_any = |w_match;

  // Scan downwards so the lowest matching slot is the one that sticks.
  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = BP_W'(i);
    end
  end

  debug_trace_buffer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .clk8      (clk8),
    .reset     (reset),
    .sample_i  (!videoBusControl),
    .addr_i    (cpuAddr),
    .rd_idx_i  (trace_rd_idx),
    .rd_addr_o (trace_rd_addr),
    .count_o   (trace_count)
  );

  logic        key_db_q;
  logic        key_db_d;
  logic [15:0] db_cnt_q;
  logic [15:0] db_cnt_d;
  logic        armed_q;
  logic        w_press;

  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = '0;
    if (_stepKey != key_db_q) begin
      if (db_cnt_q >= DEBOUNCE - 16'd1) key_db_d = _stepKey;
      else                              db_cnt_d = db_cnt_q + 16'd1;
    end
  end

  // A key held through reset must be seen released before it can step.
  always_ff @(posedge clk8) begin
    if (reset) begin
      key_db_q <= 1'b1;
      db_cnt_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      key_db_q <= key_db_d;
      db_cnt_q <= db_cnt_d;
      if (key_db_q && _stepKey) armed_q <= 1'b1;
    end
  end

  assign w_press = armed_q && key_db_q && !key_db_d;

  dbg_state_e      state_q;
  logic            halted_q;
  logic            bp_hit_q;
  logic [BP_W-1:0] bp_hit_idx_q;

  always_ff @(posedge clk8) begin
    if (reset) begin
      state_q      <= ST_RUN;
      halted_q     <= 1'b0;
      bp_hit_q     <= 1'b0;
      bp_hit_idx_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_match_any || halt_en) begin
            state_q      <= ST_HALT;
            halted_q     <= 1'b1;
            bp_hit_q     <= w_match_any;
            bp_hit_idx_q <= w_hit_idx;
          end
        end
        ST_HALT: begin
          if (w_press) begin
            state_q <= ST_STEP;
          end else if (!halt_en && !w_match_any) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            bp_hit_q <= 1'b0;
          end
        end
        ST_STEP: begin
          if (!_dtackIn) state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (key_db_d) begin
            if (halt_en || w_match_any) begin
              state_q      <= ST_HALT;
              bp_hit_q     <= w_match_any;
              bp_hit_idx_q <= w_hit_idx;
            end else begin
              state_q  <= ST_RUN;
              halted_q <= 1'b0;
              bp_hit_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign _dtackOut  = (state_q == ST_HALT || state_q == ST_RELEASE) ? 1'b1 : _dtackIn;
  assign halted     = halted_q;
  assign bp_hit     = bp_hit_q;
  assign bp_hit_idx = bp_hit_idx_q;

endmodule
`default_nettype wire
